// File: rtl/pio_pkg.sv
// pio_pkg
// Shared definitions for the PIO block: FIFO join encodings, default FIFO
// geometry and a helper that folds the reserved join encoding onto "separate".
// No ports (package).

package pio_pkg;

   typedef enum logic [1:0] {
      JOIN_NONE = 2'd0,
      JOIN_TX   = 2'd1,
      JOIN_RX   = 2'd2
   } joinMode_e;

   localparam int FIFO_WIDTH = 32;
   localparam int FIFO_DEPTH = 4;

   // Encoding 3 has no meaning of its own and behaves exactly like JOIN_NONE.
   function automatic joinMode_e normaliseJoin(input logic [1:0] raw);
      return (raw == 2'd3) ? JOIN_NONE : joinMode_e'(raw);
   endfunction

endpackage

// File: rtl/pio_fifo_ring.sv
// pio_fifo_ring
// One circular buffer with SIZE storage words and a runtime capacity limit.
// Ports:
//   i_clk, i_reset (sync, active-low), i_flush (empty this cycle)
//   i_cap      : active capacity in words (0..SIZE)
//   i_push/i_din, i_pull/o_dout (show-ahead, combinational read)
//   o_full, o_empty, o_level : derived from registered state
//   o_over, o_under          : single-cycle event pulses for the sticky flags

module pio_fifo_ring #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 8,
   parameter int LW    = $clog2(SIZE) + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic [LW-1:0]    i_cap,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pull,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_level,
   output logic             o_over,
   output logic             o_under
);

   localparam int PW = $clog2(SIZE);

   logic [WIDTH-1:0] r_mem [SIZE];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [LW-1:0]    r_level;

   logic w_full;
   logic w_empty;
   logic w_pullOk;
   logic w_pushOk;

   // A zero capacity makes the ring both full and empty, so every push and
   // pull is refused. A push into a full ring is still accepted when a pull
   // frees a slot in the same cycle.
   assign w_full   = (r_level == i_cap);
   assign w_empty  = (r_level == '0);
   assign w_pullOk = i_pull && !w_empty && !i_flush;
   assign w_pushOk = i_push && (!w_full || w_pullOk) && !i_flush;

   assign o_over   = i_push && !w_pushOk && !i_flush;
   assign o_under  = i_pull && w_empty && !i_flush;
   assign o_full   = w_full;
   assign o_empty  = w_empty;
   assign o_level  = r_level;
   assign o_dout   = r_mem[r_rdPtr];

   // Storage has no reset; contents survive reset and flush as stale data.
   always_ff @(posedge i_clk) begin
      if (i_reset && w_pushOk) begin
         r_mem[r_wrPtr] <= i_din;
      end
   end

   // Pointers wrap naturally at SIZE; level tracks accepted pushes minus pulls.
   always_ff @(posedge i_clk) begin
      if (!i_reset || i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_pushOk) r_wrPtr <= r_wrPtr + PW'(1);
         if (w_pullOk) r_rdPtr <= r_rdPtr + PW'(1);
         case ({w_pushOk, w_pullOk})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/pio_fifo_pair.sv
// pio_fifo_pair
// TX/RX FIFO pair for one PIO state machine with join modes, level reporting
// and sticky overflow/underflow flags.
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_join (0 separate, 1 TX joined, 2 RX joined, 3 = 0), i_flush, i_clear_flags
//   TX: i_tx_push/i_tx_din (system), i_tx_pull/o_tx_dout (machine),
//       o_tx_full, o_tx_empty, o_tx_level
//   RX: i_rx_push/i_rx_din (machine), i_rx_pull/o_rx_dout (system),
//       o_rx_full, o_rx_empty, o_rx_level
//   o_tx_over, o_tx_under, o_rx_over, o_rx_under : sticky flags

module pio_fifo_pair
   import pio_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int LW    = $clog2(2*DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [1:0]       i_join,
   input  logic             i_flush,
   input  logic             i_clear_flags,
   input  logic             i_tx_push,
   input  logic [WIDTH-1:0] i_tx_din,
   input  logic             i_tx_pull,
   output logic [WIDTH-1:0] o_tx_dout,
   output logic             o_tx_full,
   output logic             o_tx_empty,
   output logic [LW-1:0]    o_tx_level,
   input  logic             i_rx_push,
   input  logic [WIDTH-1:0] i_rx_din,
   input  logic             i_rx_pull,
   output logic [WIDTH-1:0] o_rx_dout,
   output logic             o_rx_full,
   output logic             o_rx_empty,
   output logic [LW-1:0]    o_rx_level,
   output logic             o_tx_over,
   output logic             o_tx_under,
   output logic             o_rx_over,
   output logic             o_rx_under
);

   joinMode_e     r_joinQ;
   joinMode_e     w_joinNew;
   logic          w_joinChange;
   logic          w_flush;
   logic [LW-1:0] w_txCap;
   logic [LW-1:0] w_rxCap;
   logic          w_txOverEvt;
   logic          w_txUnderEvt;
   logic          w_rxOverEvt;
   logic          w_rxUnderEvt;
   logic          r_txOver;
   logic          r_txUnder;
   logic          r_rxOver;
   logic          r_rxUnder;

   // A join change empties both rings in the same cycle, which also discards
   // that cycle's pushes and pulls and suppresses their flag events.
   assign w_joinNew    = normaliseJoin(i_join);
   assign w_joinChange = (w_joinNew != r_joinQ);
   assign w_flush      = i_flush || w_joinChange;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_joinQ <= JOIN_NONE;
      end else if (w_joinChange) begin
         r_joinQ <= w_joinNew;
      end
   end

   // Joining hands the whole storage of both directions to one side and
   // leaves the other with zero capacity.
   always_comb begin
      w_txCap = LW'(DEPTH);
      w_rxCap = LW'(DEPTH);
      case (r_joinQ)
         JOIN_TX: begin
            w_txCap = LW'(2*DEPTH);
            w_rxCap = '0;
         end
         JOIN_RX: begin
            w_txCap = '0;
            w_rxCap = LW'(2*DEPTH);
         end
         default: begin
            w_txCap = LW'(DEPTH);
            w_rxCap = LW'(DEPTH);
         end
      endcase
   end

   pio_fifo_ring #(.WIDTH(WIDTH), .SIZE(2*DEPTH), .LW(LW)) u_txRing (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (w_flush),
      .i_cap   (w_txCap),
      .i_push  (i_tx_push),
      .i_din   (i_tx_din),
      .i_pull  (i_tx_pull),
      .o_dout  (o_tx_dout),
      .o_full  (o_tx_full),
      .o_empty (o_tx_empty),
      .o_level (o_tx_level),
      .o_over  (w_txOverEvt),
      .o_under (w_txUnderEvt)
   );

   pio_fifo_ring #(.WIDTH(WIDTH), .SIZE(2*DEPTH), .LW(LW)) u_rxRing (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (w_flush),
      .i_cap   (w_rxCap),
      .i_push  (i_rx_push),
      .i_din   (i_rx_din),
      .i_pull  (i_rx_pull),
      .o_dout  (o_rx_dout),
      .o_full  (o_rx_full),
      .o_empty (o_rx_empty),
      .o_level (o_rx_level),
      .o_over  (w_rxOverEvt),
      .o_under (w_rxUnderEvt)
   );

   // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_txOver  <= 1'b0;
         r_txUnder <= 1'b0;
         r_rxOver  <= 1'b0;
         r_rxUnder <= 1'b0;
      end else begin
         r_txOver  <= (r_txOver  && !i_clear_flags) || w_txOverEvt;
         r_txUnder <= (r_txUnder && !i_clear_flags) || w_txUnderEvt;
         r_rxOver  <= (r_rxOver  && !i_clear_flags) || w_rxOverEvt;
         r_rxUnder <= (r_rxUnder && !i_clear_flags) || w_rxUnderEvt;
      end
   end

   assign o_tx_over  = r_txOver;
   assign o_tx_under = r_txUnder;
   assign o_rx_over  = r_rxOver;
   assign o_rx_under = r_rxUnder;

endmodule

// File: tb/tb_pio_fifo_pair.sv
// tb_pio_fifo_pair
// Self-checking bench for pio_fifo_pair (WIDTH=32, DEPTH=4). Expected words
// are queued as they are pushed and compared against show-ahead dout on pull.

module tb_pio_fifo_pair;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  join_mode;
   logic        flush;
   logic        clearFlags;
   logic        txPush;
   logic [31:0] txDin;
   logic        txPull;
   logic [31:0] txDout;
   logic        txFull;
   logic        txEmpty;
   logic [3:0]  txLevel;
   logic        rxPush;
   logic [31:0] rxDin;
   logic        rxPull;
   logic [31:0] rxDout;
   logic        rxFull;
   logic        rxEmpty;
   logic [3:0]  rxLevel;
   logic        txOver;
   logic        txUnder;
   logic        rxOver;
   logic        rxUnder;

   int passCount = 0;
   int checkCount = 0;

   logic [31:0] txQ [$];
   logic [31:0] rxQ [$];

   pio_fifo_pair #(.WIDTH(32), .DEPTH(4)) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_join        (join_mode),
      .i_flush       (flush),
      .i_clear_flags (clearFlags),
      .i_tx_push     (txPush),
      .i_tx_din      (txDin),
      .i_tx_pull     (txPull),
      .o_tx_dout     (txDout),
      .o_tx_full     (txFull),
      .o_tx_empty    (txEmpty),
      .o_tx_level    (txLevel),
      .i_rx_push     (rxPush),
      .i_rx_din      (rxDin),
      .i_rx_pull     (rxPull),
      .o_rx_dout     (rxDout),
      .o_rx_full     (rxFull),
      .o_rx_empty    (rxEmpty),
      .o_rx_level    (rxLevel),
      .o_tx_over     (txOver),
      .o_tx_under    (txUnder),
      .o_rx_over     (rxOver),
      .o_rx_under    (rxUnder)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit
   // after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      txPush = 1'b0;
      txPull = 1'b0;
      rxPush = 1'b0;
      rxPull = 1'b0;
      flush = 1'b0;
      clearFlags = 1'b0;
   endtask

   task automatic test_reset();
      idleInputs();
      join_mode = 2'd0;
      txDin = '0;
      rxDin = '0;
      reset = 1'b0;
      repeat (2) cycle();
      reset = 1'b1;
      checkCount++; if (txEmpty !== 1'b1 || txFull !== 1'b0) $display("[TB] FAIL reset_tx_status: got empty=%0b full=%0b expected empty=1 full=0", txEmpty, txFull); else passCount++;
      checkCount++; if (rxEmpty !== 1'b1 || rxFull !== 1'b0) $display("[TB] FAIL reset_rx_status: got empty=%0b full=%0b expected empty=1 full=0", rxEmpty, rxFull); else passCount++;
      checkCount++; if (txLevel !== 4'd0 || rxLevel !== 4'd0) $display("[TB] FAIL reset_levels: got tx=%0d rx=%0d expected 0 0", txLevel, rxLevel); else passCount++;
      checkCount++; if ({txOver, txUnder, rxOver, rxUnder} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b expected 0000", {txOver, txUnder, rxOver, rxUnder}); else passCount++;
   endtask

   task automatic test_tx_basic();
      logic [31:0] expWord;
      for (int v = 1; v <= 4; v++) begin
         txPush = 1'b1;
         txDin = 32'(v);
         cycle();
         txQ.push_back(32'(v));
      end
      txPush = 1'b0;
      checkCount++; if (txFull !== 1'b1 || txLevel !== 4'd4) $display("[TB] FAIL tx_fill4: got full=%0b level=%0d expected full=1 level=4", txFull, txLevel); else passCount++;
      checkCount++; if (txOver !== 1'b0) $display("[TB] FAIL tx_over_before: got %0b expected 0", txOver); else passCount++;
      txPush = 1'b1;
      txDin = 32'd5;
      cycle();
      txPush = 1'b0;
      checkCount++; if (txOver !== 1'b1 || txLevel !== 4'd4) $display("[TB] FAIL tx_overflow: got over=%0b level=%0d expected over=1 level=4", txOver, txLevel); else passCount++;
      for (int i = 0; i < 4; i++) begin
         expWord = txQ.pop_front();
         checkCount++; if (txDout !== expWord) $display("[TB] FAIL tx_pull_data: got %0h expected %0h", txDout, expWord); else passCount++;
         txPull = 1'b1;
         cycle();
      end
      txPull = 1'b0;
      checkCount++; if (txEmpty !== 1'b1 || txLevel !== 4'd0) $display("[TB] FAIL tx_drained: got empty=%0b level=%0d expected empty=1 level=0", txEmpty, txLevel); else passCount++;
      checkCount++; if (txUnder !== 1'b0) $display("[TB] FAIL tx_no_under: got %0b expected 0", txUnder); else passCount++;
      clearFlags = 1'b1;
      cycle();
      clearFlags = 1'b0;
      checkCount++; if (txOver !== 1'b0) $display("[TB] FAIL tx_over_cleared: got %0b expected 0", txOver); else passCount++;
   endtask

   task automatic test_join();
      logic [31:0] expWord;
      join_mode = 2'd1;
      cycle();
      checkCount++; if (rxFull !== 1'b1 || rxEmpty !== 1'b1) $display("[TB] FAIL join_tx_rx_zero: got full=%0b empty=%0b expected 1 1", rxFull, rxEmpty); else passCount++;
      for (int v = 0; v < 8; v++) begin
         txPush = 1'b1;
         txDin = 32'hA000 + 32'(v);
         cycle();
         txQ.push_back(32'hA000 + 32'(v));
      end
      txPush = 1'b0;
      checkCount++; if (txFull !== 1'b1 || txLevel !== 4'd8 || txOver !== 1'b0) $display("[TB] FAIL join_tx_cap8: got full=%0b level=%0d over=%0b expected 1 8 0", txFull, txLevel, txOver); else passCount++;
      for (int i = 0; i < 2; i++) begin
         expWord = txQ.pop_front();
         checkCount++; if (txDout !== expWord) $display("[TB] FAIL join_tx_data: got %0h expected %0h", txDout, expWord); else passCount++;
         txPull = 1'b1;
         cycle();
      end
      txPull = 1'b0;
      checkCount++; if (txLevel !== 4'd6) $display("[TB] FAIL join_tx_level6: got %0d expected 6", txLevel); else passCount++;
      // Join goes back to separate with a push in the same cycle; both are flushed.
      join_mode = 2'd0;
      txPush = 1'b1;
      txDin = 32'hDEAD;
      cycle();
      txPush = 1'b0;
      txQ.delete();
      checkCount++; if (txLevel !== 4'd0 || rxLevel !== 4'd0 || txOver !== 1'b0) $display("[TB] FAIL join_change_flush: got tx=%0d rx=%0d over=%0b expected 0 0 0", txLevel, rxLevel, txOver); else passCount++;
      txPull = 1'b1;
      cycle();
      txPull = 1'b0;
      checkCount++; if (txUnder !== 1'b1) $display("[TB] FAIL tx_under_empty: got %0b expected 1", txUnder); else passCount++;
      // RX joined: TX capacity zero, RX holds 8.
      join_mode = 2'd2;
      clearFlags = 1'b1;
      cycle();
      clearFlags = 1'b0;
      checkCount++; if (txFull !== 1'b1 || txEmpty !== 1'b1 || txUnder !== 1'b0) $display("[TB] FAIL join_rx_tx_zero: got full=%0b empty=%0b under=%0b expected 1 1 0", txFull, txEmpty, txUnder); else passCount++;
      for (int v = 0; v < 8; v++) begin
         rxPush = 1'b1;
         rxDin = 32'hB000 + 32'(v);
         cycle();
         rxQ.push_back(32'hB000 + 32'(v));
      end
      rxPush = 1'b0;
      checkCount++; if (rxFull !== 1'b1 || rxLevel !== 4'd8) $display("[TB] FAIL join_rx_cap8: got full=%0b level=%0d expected 1 8", rxFull, rxLevel); else passCount++;
      while (rxQ.size() > 0) begin
         expWord = rxQ.pop_front();
         checkCount++; if (rxDout !== expWord) $display("[TB] FAIL join_rx_data: got %0h expected %0h", rxDout, expWord); else passCount++;
         rxPull = 1'b1;
         cycle();
      end
      rxPull = 1'b0;
      join_mode = 2'd3;
      cycle();
      checkCount++; if (rxEmpty !== 1'b1 || rxFull !== 1'b0 || txFull !== 1'b0) $display("[TB] FAIL join3_as_none: got rx_empty=%0b rx_full=%0b tx_full=%0b expected 1 0 0", rxEmpty, rxFull, txFull); else passCount++;
   endtask

   task automatic test_wrap();
      logic [31:0] expWord;
      logic [31:0] newWord;
      for (int v = 0; v < 2; v++) begin
         txPush = 1'b1;
         txDin = 32'hC000 + 32'(v);
         cycle();
         txQ.push_back(32'hC000 + 32'(v));
      end
      for (int i = 0; i < 20; i++) begin
         expWord = txQ.pop_front();
         checkCount++; if (txDout !== expWord) $display("[TB] FAIL wrap_data: got %0h expected %0h", txDout, expWord); else passCount++;
         newWord = $urandom;
         txPush = 1'b1;
         txPull = 1'b1;
         txDin = newWord;
         cycle();
         txQ.push_back(newWord);
      end
      txPush = 1'b0;
      txPull = 1'b0;
      checkCount++; if (txLevel !== 4'd2 || txOver !== 1'b0 || txUnder !== 1'b0) $display("[TB] FAIL wrap_level: got level=%0d over=%0b under=%0b expected 2 0 0", txLevel, txOver, txUnder); else passCount++;
      while (txQ.size() > 0) begin
         expWord = txQ.pop_front();
         checkCount++; if (txDout !== expWord) $display("[TB] FAIL wrap_drain: got %0h expected %0h", txDout, expWord); else passCount++;
         txPull = 1'b1;
         cycle();
      end
      txPull = 1'b0;
   endtask

   task automatic test_boundary();
      logic [31:0] expWord;
      for (int v = 0; v < 4; v++) begin
         txPush = 1'b1;
         txDin = 32'hD000 + 32'(v);
         cycle();
         txQ.push_back(32'hD000 + 32'(v));
      end
      expWord = txQ.pop_front();
      checkCount++; if (txDout !== expWord) $display("[TB] FAIL full_pp_data: got %0h expected %0h", txDout, expWord); else passCount++;
      txPull = 1'b1;
      txDin = 32'hD0FF;
      cycle();
      txQ.push_back(32'hD0FF);
      txPush = 1'b0;
      txPull = 1'b0;
      checkCount++; if (txLevel !== 4'd4 || txFull !== 1'b1 || txOver !== 1'b0) $display("[TB] FAIL full_push_pull: got level=%0d full=%0b over=%0b expected 4 1 0", txLevel, txFull, txOver); else passCount++;
      // Flush with a pull pending: empties without raising underflow.
      flush = 1'b1;
      txPull = 1'b1;
      cycle();
      flush = 1'b0;
      txPull = 1'b0;
      txQ.delete();
      checkCount++; if (txEmpty !== 1'b1 || txUnder !== 1'b0) $display("[TB] FAIL flush_empty: got empty=%0b under=%0b expected 1 0", txEmpty, txUnder); else passCount++;
      txPush = 1'b1;
      txPull = 1'b1;
      txDin = 32'hE123;
      cycle();
      txQ.push_back(32'hE123);
      txPush = 1'b0;
      txPull = 1'b0;
      checkCount++; if (txLevel !== 4'd1 || txUnder !== 1'b1) $display("[TB] FAIL empty_push_pull: got level=%0d under=%0b expected 1 1", txLevel, txUnder); else passCount++;
      expWord = txQ.pop_front();
      checkCount++; if (txDout !== expWord) $display("[TB] FAIL empty_pp_data: got %0h expected %0h", txDout, expWord); else passCount++;
      txPull = 1'b1;
      clearFlags = 1'b1;
      cycle();
      txPull = 1'b0;
      clearFlags = 1'b0;
   endtask

   task automatic test_reset_flags();
      logic [31:0] expWord;
      for (int v = 0; v < 3; v++) begin
         rxPush = 1'b1;
         rxDin = 32'hF000 + 32'(v);
         cycle();
      end
      rxPush = 1'b0;
      rxPull = 1'b1;
      checkCount++; if (rxLevel !== 4'd3) $display("[TB] FAIL rx_level3: got %0d expected 3", rxLevel); else passCount++;
      // Reset with pulls and an RX pull active: everything discarded.
      txPull = 1'b1;
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      rxPull = 1'b0;
      txPull = 1'b0;
      checkCount++; if (rxEmpty !== 1'b1 || rxLevel !== 4'd0) $display("[TB] FAIL reset_rx_empty: got empty=%0b level=%0d expected 1 0", rxEmpty, rxLevel); else passCount++;
      checkCount++; if ({txOver, txUnder, rxOver, rxUnder} !== 4'b0000) $display("[TB] FAIL reset_flags_mid: got %b expected 0000", {txOver, txUnder, rxOver, rxUnder}); else passCount++;
      for (int v = 0; v < 4; v++) begin
         rxPush = 1'b1;
         rxDin = 32'h1100 + 32'(v);
         cycle();
         rxQ.push_back(32'h1100 + 32'(v));
      end
      rxPush = 1'b1;
      rxDin = 32'h1199;
      clearFlags = 1'b1;
      cycle();
      rxPush = 1'b0;
      clearFlags = 1'b0;
      checkCount++; if (rxOver !== 1'b1 || rxLevel !== 4'd4) $display("[TB] FAIL clear_vs_set: got over=%0b level=%0d expected 1 4", rxOver, rxLevel); else passCount++;
      while (rxQ.size() > 0) begin
         expWord = rxQ.pop_front();
         checkCount++; if (rxDout !== expWord) $display("[TB] FAIL rx_after_reset_data: got %0h expected %0h", rxDout, expWord); else passCount++;
         rxPull = 1'b1;
         cycle();
      end
      rxPull = 1'b0;
      clearFlags = 1'b1;
      cycle();
      clearFlags = 1'b0;
      checkCount++; if (rxOver !== 1'b0 || rxUnder !== 1'b0) $display("[TB] FAIL rx_flags_cleared: got over=%0b under=%0b expected 0 0", rxOver, rxUnder); else passCount++;
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_join();
      test_wrap();
      test_boundary();
      test_reset_flags();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
